// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit, BAUD_DIV clocks per bit.
// Defining SERIAL_TX_PARITY_EN inserts an even-parity bit between the data and stop bits.
module serial_tx #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              load,
  output logic              ready,
  output logic              txd,
  output logic              done
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_PRE  = CW'((BAUD_DIV > 1) ? BAUD_DIV - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic          ONE_CYCLE = (BAUD_DIV == 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state;
  logic [CW-1:0]     baud_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shnext;
  logic              last_tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              par;
`endif

  assign last_tick = (baud_cnt == BAUD_LAST);
  assign shnext    = shreg >> 1;

  // Outputs are computed for the cycle being entered, so txd/ready/done are
  // plain flops; done is raised one cycle early so it lands on the last stop cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          txd   <= 1'b1;
          ready <= 1'b1;
          if (load) begin
            shreg    <= din;
`ifdef SERIAL_TX_PARITY_EN
            par      <= ^din;
`endif
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b0;
            ready    <= 1'b0;
            state    <= START;
          end
        end

        START: begin
          if (last_tick) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (last_tick) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
              txd     <= par;
              state   <= PARITY;
`else
              txd     <= 1'b1;
              done    <= ONE_CYCLE;
              state   <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= shnext;
              txd     <= shnext[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (last_tick) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            done     <= ONE_CYCLE;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (last_tick) begin
            baud_cnt <= '0;
            txd      <= 1'b1;
            ready    <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
            done     <= (baud_cnt == BAUD_PRE);
          end
        end

        default: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          txd      <= 1'b1;
          ready    <= 1'b1;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default instance (BAUD_DIV=4) plus a BAUD_DIV=1 instance.
module tb_serial_tx;

  localparam int DW = 8;
  localparam int BD = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif
  localparam int FL  = NB * BD;
  localparam int FL1 = NB;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din, din1;
  logic          load, load1;
  logic          ready, txd, done;
  logic          ready1, txd1, done1;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(DW), .BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .din(din), .load(load),
    .ready(ready), .txd(txd), .done(done)
  );

  serial_tx #(.DATA_W(DW), .BAUD_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .load(load1),
    .ready(ready1), .txd(txd1), .done(done1)
  );

  // Expected line levels, one entry per bit slot: start, data LSB first, [parity], stop.
  function automatic logic [NB-1:0] frameBits(input logic [DW-1:0] d);
    logic [NB-1:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
    b[DW+1] = ^d;
`endif
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic ld);
    @(posedge clk);
    #1;
    din  = d;
    load = ld;
  endtask

  task automatic checkIdle(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput($sformatf("%s txd", tag), txd, 1'b1);
      checkOutput($sformatf("%s ready", tag), ready, 1'b1);
      checkOutput($sformatf("%s done", tag), done, 1'b0);
    end
  endtask

  // Sends one frame on the default instance; optional stray load pulse or reset at a given cycle.
  task automatic runFrame(input logic [DW-1:0] d, input int pulseAt, input int rstAt);
    logic [NB-1:0] bits;
    bits = frameBits(d);
    applyStimulus(d, 1'b1);
    @(posedge clk);
    #1;
    load = 1'b0;
    din  = ~d;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      checkOutput($sformatf("txd %h c%0d", d, k), txd, bits[(k-1)/BD]);
      checkOutput($sformatf("done %h c%0d", d, k), done, k == FL);
      checkOutput($sformatf("ready %h c%0d", d, k), ready, 1'b0);
      if (k == pulseAt) begin
        din  = 8'hFF;
        load = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
      end
      if (k == rstAt) begin
        rst  = 1'b1;
        load = 1'b1;
        #1;
        checkOutput("async rst txd", txd, 1'b1);
        checkOutput("async rst ready", ready, 1'b1);
        checkOutput("async rst done", done, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("rst held txd", txd, 1'b1);
        checkOutput("rst held ready", ready, 1'b1);
        load = 1'b0;
        rst  = 1'b0;
        checkIdle("post rst", 3);
        return;
      end
    end
    checkIdle($sformatf("after %h", d), 4);
  endtask

  initial begin
    logic [NB-1:0] b0, b1;
    int pos, f;

    rst = 1'b0; load = 1'b0; din = '0; load1 = 1'b0; din1 = '0;
    #2;
    rst = 1'b1;
    load = 1'b1;
    #1;
    checkOutput("reset txd", txd, 1'b1);
    checkOutput("reset ready", ready, 1'b1);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset txd1", txd1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("load during rst ignored", txd, 1'b1);
    load = 1'b0;
    rst  = 1'b0;
    checkIdle("idle", 2);

    runFrame(8'hA5, 0, 0);
    runFrame(8'h07, 0, 0);
    runFrame(8'h5A, 10, 0);
    runFrame(8'hC3, 0, 15);
    runFrame(8'h3C, 0, 0);

    // Continuous load on the one-cycle-per-bit instance: two frames, one idle cycle between.
    b0 = frameBits(8'h00);
    b1 = frameBits(8'hFF);
    @(posedge clk);
    #1;
    din1  = 8'h00;
    load1 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 2*(FL1+1) + 2; k++) begin
      @(negedge clk);
      pos = (k-1) % (FL1+1);
      f   = (k-1) / (FL1+1);
      if (f < 2 && pos < FL1) begin
        checkOutput($sformatf("b2b txd c%0d", k), txd1, (f == 0) ? b0[pos] : b1[pos]);
        checkOutput($sformatf("b2b done c%0d", k), done1, pos == FL1-1);
        checkOutput($sformatf("b2b ready c%0d", k), ready1, 1'b0);
      end else begin
        checkOutput($sformatf("b2b idle txd c%0d", k), txd1, 1'b1);
        checkOutput($sformatf("b2b idle done c%0d", k), done1, 1'b0);
        checkOutput($sformatf("b2b idle ready c%0d", k), ready1, 1'b1);
      end
      if (k == 2) din1 = 8'hFF;
      if (k == FL1 + 2) load1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
